ball_ctl: RTL



---
 rtl/pong_pkg.sv | 38 +++
 rtl/ball_ctl_if.sv | 22 ++
 rtl/ball_ctl_frame_tick.sv | 19 +
 rtl/ball_ctl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong screen geometry, ball FSM state encoding and small helpers.
package pong_pkg;

   localparam int SCREEN_W    = 1024;
   localparam int SCREEN_H    = 768;
   localparam int BALL_SIZE   = 16;
   localparam int PADDLE_X    = 32;
   localparam int PADDLE_W    = 16;
   localparam int PADDLE_H    = 128;
   localparam int SPEED       = 4;
   localparam int SERVE_DELAY = 60;
   localparam int LIVES       = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      MOVE  = 3'd2,
      MISS  = 3'd3,
      OVER  = 3'd4
   } ball_state_e;

   localparam logic [11:0] BALL_X0     = 12'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [11:0] BALL_Y0     = 12'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [11:0] X_MAX       = 12'(SCREEN_W - BALL_SIZE);
   localparam logic [11:0] Y_MAX       = 12'(SCREEN_H - BALL_SIZE);
   localparam logic [11:0] PADDLE_FACE = 12'(PADDLE_X + PADDLE_W);
   localparam logic [11:0] STEP        = 12'(SPEED);
   localparam logic [12:0] BALL_SIZE_13 = 13'(BALL_SIZE);
   localparam logic [12:0] PADDLE_H_13  = 13'(PADDLE_H);
   localparam logic [5:0]  SERVE_LAST  = 6'(SERVE_DELAY - 1);
   localparam logic [1:0]  LIVES_INIT  = 2'(LIVES);

   // Widen a screen coordinate so sums near 4095 cannot wrap.
   function automatic logic [12:0] ext13(input logic [11:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/ball_ctl_if.sv
// Ball engine bus: per-frame inputs from timing/mouse, ball state to renderer.
interface ball_ctl_if;
   logic        vblnk_in;
   logic        enable;
   logic [11:0] paddle_y;
   logic [11:0] ball_x;
   logic [11:0] ball_y;
   logic [1:0]  lives;
   logic [7:0]  hits;
   logic        miss;
   logic        game_over;

   modport master (
      output vblnk_in, enable, paddle_y,
      input  ball_x, ball_y, lives, hits, miss, game_over
   );

   modport slave (
      input  vblnk_in, enable, paddle_y,
      output ball_x, ball_y, lives, hits, miss, game_over
   );
endinterface

// File: rtl/ball_ctl_frame_tick.sv
// Frame tick: one-cycle pulse on each rising edge of vertical blank.
module frame_tick (
   input  logic clk,
   input  logic rst,
   input  logic vblnk_in,
   output logic tick
);

   logic vblnk_q;

   // Remember last cycle's vblank level for edge detection.
   always_ff @(posedge clk) begin
      if (!rst) vblnk_q <= 1'b0;
      else      vblnk_q <= vblnk_in;
   end

   assign tick = vblnk_in & ~vblnk_q;

endmodule

// File: rtl/ball_ctl.sv
// Ball physics: per-frame motion, wall/paddle bounces, lives and hit count.
//
// state | meaning
// IDLE  | not in game; ball centred, score cleared
// SERVE | ball held at centre for SERVE_DELAY frames
// MOVE  | ball advances SPEED px per axis each frame
// MISS  | ball left the screen; one cycle to take a life
// OVER  | no lives left; frozen until enable drops
module ball_ctl
   import pong_pkg::*;
(
   input logic       clk,
   input logic       rst,
   ball_ctl_if.slave bus
);

   ball_state_e state, state_nx;
   logic        tick;
   logic [11:0] ball_x, ball_y;
   logic        dx, dy;            // 1 = moving towards larger coordinate
   logic [1:0]  lives;
   logic [7:0]  hits;
   logic [5:0]  serve_cnt;

   logic [11:0] mv_x, mv_y;
   logic        mv_dx, mv_dy, mv_hit, mv_out;
   logic        in_plane, overlap;

   frame_tick u_tick (
      .clk      (clk),
      .rst      (rst),
      .vblnk_in (bus.vblnk_in),
      .tick     (tick)
   );

   // Ball is crossing the paddle face this frame (ball_x >= face guards the subtract).
   assign in_plane = (ball_x >= PADDLE_FACE) &&
                     (ext13(ball_x) - ext13(STEP) <= ext13(PADDLE_FACE));
   assign overlap  = (ext13(ball_y) + BALL_SIZE_13 > ext13(bus.paddle_y)) &&
                     (ext13(ball_y) < ext13(bus.paddle_y) + PADDLE_H_13);

   // Horizontal step: right wall, paddle face, left-edge exit.
   always_comb begin
      mv_x   = ball_x;
      mv_dx  = dx;
      mv_hit = 1'b0;
      mv_out = 1'b0;
      if (dx) begin
         if (ext13(ball_x) + ext13(STEP) >= ext13(X_MAX)) begin
            mv_x  = X_MAX;
            mv_dx = 1'b0;
         end else begin
            mv_x = ball_x + STEP;
         end
      end else if (in_plane && overlap) begin
         mv_x   = PADDLE_FACE;
         mv_dx  = 1'b1;
         mv_hit = 1'b1;
      end else if (ball_x < STEP) begin
         mv_x   = '0;
         mv_out = 1'b1;
      end else begin
         mv_x = ball_x - STEP;
      end
   end

   // Vertical step: bottom and top walls.
   always_comb begin
      mv_y  = ball_y;
      mv_dy = dy;
      if (dy) begin
         if (ext13(ball_y) + ext13(STEP) >= ext13(Y_MAX)) begin
            mv_y  = Y_MAX;
            mv_dy = 1'b0;
         end else begin
            mv_y = ball_y + STEP;
         end
      end else if (ball_y <= STEP) begin
         mv_y  = '0;
         mv_dy = 1'b1;
      end else begin
         mv_y = ball_y - STEP;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state decode; dropping enable overrides everything.
   always_comb begin
      state_nx = state;
      if (!bus.enable) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = SERVE;
            SERVE:   if (tick && serve_cnt == SERVE_LAST) state_nx = MOVE;
            MOVE:    if (tick && mv_out) state_nx = MISS;
            MISS:    state_nx = (lives == 2'd1) ? OVER : SERVE;
            OVER:    state_nx = OVER;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Status outputs decoded from state.
   always_comb begin
      bus.miss      = (state == MISS);
      bus.game_over = (state == OVER);
   end

   // Ball position, direction, lives, hits and serve counter.
   always_ff @(posedge clk) begin
      if (!rst || !bus.enable) begin
         ball_x    <= BALL_X0;
         ball_y    <= BALL_Y0;
         dx        <= 1'b1;
         dy        <= 1'b1;
         lives     <= LIVES_INIT;
         hits      <= '0;
         serve_cnt <= '0;
      end else begin
         case (state)
            IDLE: serve_cnt <= '0;
            SERVE: begin
               ball_x <= BALL_X0;
               ball_y <= BALL_Y0;
               if (tick) serve_cnt <= serve_cnt + 6'd1;
            end
            MOVE: begin
               if (tick) begin
                  ball_x <= mv_x;
                  ball_y <= mv_y;
                  dx     <= mv_dx;
                  dy     <= mv_dy;
                  if (mv_hit && hits != 8'hFF) hits <= hits + 8'd1;
               end
            end
            MISS: begin
               lives     <= lives - 2'd1;
               ball_x    <= BALL_X0;
               ball_y    <= BALL_Y0;
               dx        <= 1'b1;
               dy        <= ~dy;
               serve_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.ball_x = ball_x;
   assign bus.ball_y = ball_y;
   assign bus.lives  = lives;
   assign bus.hits   = hits;

endmodule
